// File: rtl/counter_arb_ctrl_if.sv
// rtl/counter_arb_ctrl_if.sv - request/grant/counter bundle for counter_arb_ctrl.
// The pause signal exists only when CNT_PAUSE_EN is defined.
interface counter_arb_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       req;
    logic [1:0]       dir;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
`ifdef CNT_PAUSE_EN
    logic             pause;
`endif
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic [WIDTH-1:0] q;

    modport master (
`ifdef CNT_PAUSE_EN
        output pause,
`endif
        output req, dir, len0, len1,
        input  gnt, done, busy, q
    );

    modport slave (
`ifdef CNT_PAUSE_EN
        input  pause,
`endif
        input  req, dir, len0, len1,
        output gnt, done, busy, q
    );
endinterface

// File: rtl/counter_arb_ctrl.sv
// rtl/counter_arb_ctrl.sv - two-requester round-robin arbiter owning a shared up/down counter.
// Optional run pause is enabled by defining CNT_PAUSE_EN.
module counter_arb_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    counter_arb_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic             ptr;
    logic             owner;
    logic             dir_r;
    logic [WIDTH-1:0] remain;
    logic [WIDTH-1:0] q_r;
    logic [1:0]       gnt_r;
    logic [1:0]       done_r;
    logic             busy_r;

    logic             win_id;
    logic [WIDTH-1:0] win_len;
    logic             win_dir;
    logic             run_go;

    // A sole requester wins outright; contention is settled by the pointer.
    always_comb begin
        win_id = ptr;
        if (bus.req == 2'b01)
            win_id = 1'b0;
        else if (bus.req == 2'b10)
            win_id = 1'b1;
        win_len = win_id ? bus.len1 : bus.len0;
        win_dir = bus.dir[win_id];
    end

`ifdef CNT_PAUSE_EN
    assign run_go = !bus.pause;
`else
    assign run_go = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            owner  <= 1'b0;
            dir_r  <= 1'b0;
            remain <= '0;
            q_r    <= '0;
            gnt_r  <= 2'b00;
            done_r <= 2'b00;
            busy_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner  <= win_id;
                        dir_r  <= win_dir;
                        remain <= win_len;
                        gnt_r  <= {win_id, ~win_id};
                        busy_r <= 1'b1;
                        if (win_len == '0) begin
                            state  <= DONE;
                            done_r <= {win_id, ~win_id};
                        end else begin
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (run_go) begin
                        q_r    <= dir_r ? q_r + WIDTH'(1) : q_r - WIDTH'(1);
                        remain <= remain - WIDTH'(1);
                        if (remain == WIDTH'(1)) begin
                            state  <= DONE;
                            done_r <= gnt_r;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    gnt_r  <= 2'b00;
                    done_r <= 2'b00;
                    busy_r <= 1'b0;
                    ptr    <= ~owner;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt  = gnt_r;
    assign bus.done = done_r;
    assign bus.busy = busy_r;
    assign bus.q    = q_r;
endmodule

// File: tb/tb_counter_arb_ctrl.sv
// tb/tb_counter_arb_ctrl.sv - self-checking bench for counter_arb_ctrl (CNT_PAUSE_EN optional).
module tb_counter_arb_ctrl;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    counter_arb_ctrl_if #(.WIDTH(WIDTH)) bus ();

    counter_arb_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       req;
        logic [1:0]       dir;
        logic [WIDTH-1:0] len0;
        logic [WIDTH-1:0] len1;
        logic [1:0]       gnt;
        logic [1:0]       done;
        logic             busy;
        logic [WIDTH-1:0] q;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] req, input logic [1:0] dir, input int l0, input int l1,
                       input logic [1:0] gnt, input logic [1:0] done, input logic busy, input int q);
        vec_t v;
        v.req = req; v.dir = dir; v.len0 = WIDTH'(l0); v.len1 = WIDTH'(l1);
        v.gnt = gnt; v.done = done; v.busy = busy; v.q = WIDTH'(q);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] dir, input int l0, input int l1);
        bus.req = req; bus.dir = dir; bus.len0 = WIDTH'(l0); bus.len1 = WIDTH'(l1);
    endtask

    task automatic step_chk(input string tag, input logic [1:0] gnt, input logic [1:0] done,
                            input logic busy, input int q);
        @(posedge clk);
        #1;
        chk({tag, ".gnt"},  32'(bus.gnt),  32'(gnt));
        chk({tag, ".done"}, 32'(bus.done), 32'(done));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(busy));
        chk({tag, ".q"},    32'(bus.q),    32'(q));
    endtask

    initial begin
        // Cycle table: inputs applied before the edge, outputs expected after it.
        add(2'b01, 2'b01, 3, 0, 2'b01, 2'b00, 1, 0);
        add(2'b00, 2'b00, 9, 9, 2'b01, 2'b00, 1, 1);
        add(2'b00, 2'b00, 9, 9, 2'b01, 2'b00, 1, 2);
        add(2'b00, 2'b00, 9, 9, 2'b01, 2'b01, 1, 3);
        add(2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 3);
        add(2'b01, 2'b00, 2, 0, 2'b01, 2'b00, 1, 3);
        add(2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 1, 2);
        add(2'b00, 2'b00, 0, 0, 2'b01, 2'b01, 1, 1);
        add(2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1);
        add(2'b10, 2'b00, 0, 3, 2'b10, 2'b00, 1, 1);
        add(2'b00, 2'b00, 0, 0, 2'b10, 2'b00, 1, 0);
        add(2'b00, 2'b00, 0, 0, 2'b10, 2'b00, 1, 15);
        add(2'b00, 2'b00, 0, 0, 2'b10, 2'b10, 1, 14);
        add(2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 14);
        add(2'b11, 2'b11, 2, 2, 2'b01, 2'b00, 1, 14);
        add(2'b11, 2'b11, 2, 2, 2'b01, 2'b00, 1, 15);
        add(2'b11, 2'b11, 2, 2, 2'b01, 2'b01, 1, 0);
        add(2'b11, 2'b11, 2, 2, 2'b00, 2'b00, 0, 0);
        add(2'b11, 2'b11, 2, 2, 2'b10, 2'b00, 1, 0);
        add(2'b11, 2'b11, 2, 2, 2'b10, 2'b00, 1, 1);
        add(2'b11, 2'b11, 2, 2, 2'b10, 2'b10, 1, 2);
        add(2'b11, 2'b11, 2, 2, 2'b00, 2'b00, 0, 2);
        add(2'b11, 2'b11, 2, 2, 2'b01, 2'b00, 1, 2);
        add(2'b11, 2'b11, 2, 2, 2'b01, 2'b00, 1, 3);
        add(2'b11, 2'b11, 2, 2, 2'b01, 2'b01, 1, 4);
        add(2'b11, 2'b11, 2, 2, 2'b00, 2'b00, 0, 4);
        add(2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 4);
        add(2'b01, 2'b00, 0, 0, 2'b01, 2'b01, 1, 4);
        add(2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 4);

        drive(2'b00, 2'b00, 0, 0);
`ifdef CNT_PAUSE_EN
        bus.pause = 1'b0;
`endif
        rst = 1'b0;
        #12;
        chk("reset.gnt",  32'(bus.gnt),  32'h0);
        chk("reset.done", 32'(bus.done), 32'h0);
        chk("reset.busy", 32'(bus.busy), 32'h0);
        chk("reset.q",    32'(bus.q),    32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].req, vecs[i].dir, int'(vecs[i].len0), int'(vecs[i].len1));
            step_chk($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].busy, int'(vecs[i].q));
        end

        // Reset mid-run at q=5 with pointer at requester 1.
        drive(2'b01, 2'b01, 5, 0);
        step_chk("mid.acc", 2'b01, 2'b00, 1, 4);
        drive(2'b00, 2'b00, 0, 0);
        step_chk("mid.step", 2'b01, 2'b00, 1, 5);
        #1 rst = 1'b0;
        #1;
        chk("async.q",    32'(bus.q),    32'h0);
        chk("async.gnt",  32'(bus.gnt),  32'h0);
        chk("async.busy", 32'(bus.busy), 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 chk("async.nodone", 32'(bus.done), 32'h0);
        end
        rst = 1'b1;
        drive(2'b11, 2'b11, 1, 1);
        step_chk("post.ptr0", 2'b01, 2'b00, 1, 0);
        drive(2'b00, 2'b00, 0, 0);
        step_chk("post.done", 2'b01, 2'b01, 1, 1);
        step_chk("post.idle", 2'b00, 2'b00, 0, 1);

`ifdef CNT_PAUSE_EN
        // Pause in IDLE is ignored; two paused RUN cycles delay done by two.
        drive(2'b01, 2'b01, 4, 0);
        bus.pause = 1'b1;
        step_chk("pz.acc", 2'b01, 2'b00, 1, 1);
        drive(2'b00, 2'b00, 0, 0);
        bus.pause = 1'b0;
        step_chk("pz.s1", 2'b01, 2'b00, 1, 2);
        bus.pause = 1'b1;
        step_chk("pz.h1", 2'b01, 2'b00, 1, 2);
        step_chk("pz.h2", 2'b01, 2'b00, 1, 2);
        bus.pause = 1'b0;
        step_chk("pz.s2", 2'b01, 2'b00, 1, 3);
        step_chk("pz.s3", 2'b01, 2'b00, 1, 4);
        step_chk("pz.s4", 2'b01, 2'b01, 1, 5);
        step_chk("pz.idle", 2'b00, 2'b00, 0, 5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
